// File: rtl/rcu_bc_pkg.sv
// Shared constants for the BoardController slow-control input path.
package rcu_bc_pkg;

    localparam int   GLITCH_CNT_W = 8;
    localparam logic I2C_IDLE_LVL = 1'b1;

    // The stable counter must be able to hold FILT_LEN-1; never narrower than one bit.
    function automatic int filt_cnt_width(input int filt_len);
        int w;
        w = $clog2(filt_len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rcu_deglitch_ch.sv
// One channel: synchroniser, stable-count glitch filter and rise/fall strobes.
// Optional per-channel glitch counter with RCU_DEGLITCH_GLITCH_CNT_EN.
module rcu_deglitch_ch
    import rcu_bc_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = 4,
    parameter logic RST_VAL     = I2C_IDLE_LVL
) (
    input  logic clk_40m,
    input  logic rst_n,
    input  logic sig_i,
    output logic sig_o,
    output logic rise_o,
`ifdef RCU_DEGLITCH_GLITCH_CNT_EN
    output logic fall_o,
    input  logic glitch_clr_i,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
`else
    output logic fall_o
`endif
);

    localparam int               CNT_W   = filt_cnt_width(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_d, rise_d, fall_d;

    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A new level is only taken once it has been seen FILT_LEN times in a row.
    always_comb begin
        cnt_d  = cnt_q;
        lvl_d  = sig_o;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == sig_o) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            lvl_d  = s;
            rise_d = s;
            fall_d = ~s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sig_o  <= RST_VAL;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sig_o  <= lvl_d;
            rise_o <= rise_d;
            fall_o <= fall_d;
        end
    end

`ifdef RCU_DEGLITCH_GLITCH_CNT_EN
    logic glitch_hit;

    // A non-zero count that collapses back to the current level is a rejected excursion.
    assign glitch_hit = (s == sig_o) && (cnt_q != '0);

    always_ff @(posedge clk_40m or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt_o <= '0;
        end else if (glitch_clr_i) begin
            glitch_cnt_o <= '0;
        end else if (glitch_hit && (glitch_cnt_o != '1)) begin
            glitch_cnt_o <= glitch_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/rcu_signal_deglitch.sv
// Multi-channel input conditioner for slow asynchronous RCU control lines (SCL/SDA).
// Glitch counters and their clear input exist only with RCU_DEGLITCH_GLITCH_CNT_EN.
module rcu_signal_deglitch
    import rcu_bc_pkg::*;
#(
    parameter int              N_CH        = 2,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILT_LEN    = 4,
    parameter logic [N_CH-1:0] RST_VAL     = {N_CH{I2C_IDLE_LVL}}
) (
    input  logic                          clk_40m,
    input  logic                          rst_n,
    input  logic [N_CH-1:0]               sig_i,
    output logic [N_CH-1:0]               sig_o,
    output logic [N_CH-1:0]               rise_o,
`ifdef RCU_DEGLITCH_GLITCH_CNT_EN
    output logic [N_CH-1:0]               fall_o,
    input  logic                          glitch_clr_i,
    output logic [GLITCH_CNT_W*N_CH-1:0]  glitch_cnt_o
`else
    output logic [N_CH-1:0]               fall_o
`endif
);

    // Legal ranges: SYNC_STAGES 2..4, FILT_LEN 1..255.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        rcu_deglitch_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .RST_VAL     (RST_VAL[c])
        ) u_ch (
            .clk_40m      (clk_40m),
            .rst_n        (rst_n),
            .sig_i        (sig_i[c]),
            .sig_o        (sig_o[c]),
            .rise_o       (rise_o[c]),
`ifdef RCU_DEGLITCH_GLITCH_CNT_EN
            .fall_o       (fall_o[c]),
            .glitch_clr_i (glitch_clr_i),
            .glitch_cnt_o (glitch_cnt_o[GLITCH_CNT_W*c +: GLITCH_CNT_W])
`else
            .fall_o       (fall_o[c])
`endif
        );
    end

endmodule

// File: tb/tb_rcu_signal_deglitch.sv
// Scoreboard bench for rcu_signal_deglitch at default parameters.
`timescale 1ns/100ps
module tb_rcu_signal_deglitch;

    // Stimulus driven after posedge C is first sampled at C+1; strobe shows at C+6.
    localparam int LAT = 6;

    typedef struct {
        int         cyc;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] lvl;
    } exp_t;

    logic       clk_40m = 1'b0;
    logic       rst_n;
    logic [1:0] sig_i;
    logic [1:0] sig_o, rise_o, fall_o;
`ifdef RCU_DEGLITCH_GLITCH_CNT_EN
    logic        glitch_clr_i;
    logic [15:0] glitch_cnt_o;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t;
    exp_t exp_q[$];
    exp_t mon_e;

    rcu_signal_deglitch dut (
        .clk_40m      (clk_40m),
        .rst_n        (rst_n),
        .sig_i        (sig_i),
        .sig_o        (sig_o),
        .rise_o       (rise_o),
`ifdef RCU_DEGLITCH_GLITCH_CNT_EN
        .fall_o       (fall_o),
        .glitch_clr_i (glitch_clr_i),
        .glitch_cnt_o (glitch_cnt_o)
`else
        .fall_o       (fall_o)
`endif
    );

    always #12.5 clk_40m = ~clk_40m;

    always @(posedge clk_40m) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expectStrobe(input int at, input logic [1:0] rise, input logic [1:0] fall, input logic [1:0] lvl);
        exp_t e;
        e.cyc  = at;
        e.rise = rise;
        e.fall = fall;
        e.lvl  = lvl;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] val, input int hold);
        sig_i = val;
        repeat (hold) @(negedge clk_40m);
    endtask

    // Monitor: every strobe must match the oldest expectation; overdue ones are reported missing.
    always @(negedge clk_40m) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checkOutput("strobe_missing", 16'(cyc), 16'(exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        if ((rise_o | fall_o) != 2'b00) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_strobe", {12'd0, rise_o, fall_o}, 16'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("strobe_cycle", 16'(cyc), 16'(mon_e.cyc));
                checkOutput("strobe_rise", 16'(rise_o), 16'(mon_e.rise));
                checkOutput("strobe_fall", 16'(fall_o), 16'(mon_e.fall));
                checkOutput("strobe_level", 16'(sig_o), 16'(mon_e.lvl));
            end
        end
    end

    initial begin
        #100us;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        sig_i = 2'b00;
`ifdef RCU_DEGLITCH_GLITCH_CNT_EN
        glitch_clr_i = 1'b0;
`endif
        repeat (3) @(negedge clk_40m);
        checkOutput("reset_sig_o", 16'(sig_o), 16'h3);
        checkOutput("reset_rise", 16'(rise_o), 16'h0);
        checkOutput("reset_fall", 16'(fall_o), 16'h0);

        // Release with both pins low: idle-high outputs fall together after the full latency.
        rst_n = 1'b1;
        t = cyc;
        expectStrobe(t + LAT, 2'b00, 2'b11, 2'b00);
        @(negedge clk_40m);
        checkOutput("release_sig_o", 16'(sig_o), 16'h3);
        repeat (9) @(negedge clk_40m);

        t = cyc;
        expectStrobe(t + LAT, 2'b11, 2'b00, 2'b11);
        applyStimulus(2'b11, 10);

        // Latency on channel 0 only.
        t = cyc;
        expectStrobe(t + LAT, 2'b00, 2'b01, 2'b10);
        applyStimulus(2'b10, LAT - 1);
        checkOutput("latency_before", 16'(sig_o), 16'h3);
        @(negedge clk_40m);
        checkOutput("latency_after", 16'(sig_o), 16'h2);
        repeat (4) @(negedge clk_40m);
        t = cyc;
        expectStrobe(t + LAT, 2'b01, 2'b00, 2'b11);
        applyStimulus(2'b11, 10);

        // Three-cycle low on SDA is rejected.
        applyStimulus(2'b01, 3);
        applyStimulus(2'b11, 10);
        checkOutput("glitch3_sig_o", 16'(sig_o), 16'h3);

        // Four-cycle low on SDA is accepted and then released four cycles later.
        t = cyc;
        expectStrobe(t + LAT, 2'b00, 2'b10, 2'b01);
        expectStrobe(t + 4 + LAT, 2'b10, 2'b00, 2'b11);
        applyStimulus(2'b01, 4);
        applyStimulus(2'b11, 12);

        // Simultaneous fall, then a two-cycle high pulse that must not appear.
        t = cyc;
        expectStrobe(t + LAT, 2'b00, 2'b11, 2'b00);
        applyStimulus(2'b00, 8);
        applyStimulus(2'b11, 2);
        applyStimulus(2'b00, 10);
        checkOutput("pulse2_sig_o", 16'(sig_o), 16'h0);

        // Reset while the rising count sits at 2: pending acceptance is dropped.
        applyStimulus(2'b11, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_sig_o", 16'(sig_o), 16'h3);
        checkOutput("midreset_rise", 16'(rise_o), 16'h0);
        checkOutput("midreset_fall", 16'(fall_o), 16'h0);
        repeat (2) @(negedge clk_40m);
        rst_n = 1'b1;
        repeat (12) @(negedge clk_40m);
        checkOutput("postreset_sig_o", 16'(sig_o), 16'h3);

`ifdef RCU_DEGLITCH_GLITCH_CNT_EN
        checkOutput("gcnt_reset", glitch_cnt_o, 16'h0000);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(2'b10, 1);
            applyStimulus(2'b11, 1);
        end
        repeat (6) @(negedge clk_40m);
        checkOutput("gcnt_ch0_sat", 16'(glitch_cnt_o[7:0]), 16'd255);
        checkOutput("gcnt_ch1_zero", 16'(glitch_cnt_o[15:8]), 16'd0);

        glitch_clr_i = 1'b1;
        applyStimulus(2'b10, 1);
        applyStimulus(2'b11, 4);
        glitch_clr_i = 1'b0;
        @(negedge clk_40m);
        checkOutput("gcnt_clr_wins", 16'(glitch_cnt_o[7:0]), 16'd0);
        applyStimulus(2'b10, 1);
        applyStimulus(2'b11, 4);
        checkOutput("gcnt_after_clr", 16'(glitch_cnt_o[7:0]), 16'd1);
`endif

        repeat (3) @(negedge clk_40m);
        checkOutput("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
